// File: rtl/sar_search_ctrl_if.sv
// rtl/sar_search_ctrl_if.sv - start/comparator/result signal bundle for the SAR search controller
interface sar_search_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] cmp_a;
    logic         cmp_e;
    logic         cmp_g;
    logic         cmp_l;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    // Environment side: issues start and returns comparator flags
    modport master (
        output start, cmp_e, cmp_g, cmp_l,
        input  cmp_a, busy, done, result, err
    );

    // Controller side
    modport slave (
        input  start, cmp_e, cmp_g, cmp_l,
        output cmp_a, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - binary-search controller driving an external comparator (optional SAR_EARLY_EXIT_EN)
module sar_search_ctrl #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.slave  bus
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

    typedef enum logic {IDLE, TRY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  trial_q, trial_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic          one_hot;
    logic [W-1:0]  idx_bit;
    logic [W-1:0]  kept;

    // State and output registers; everything returns to idle on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Next-state: resolve one bit per cycle from the comparator flags
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        one_hot = ( bus.cmp_e & ~bus.cmp_g & ~bus.cmp_l) |
                  (~bus.cmp_e &  bus.cmp_g & ~bus.cmp_l) |
                  (~bus.cmp_e & ~bus.cmp_g &  bus.cmp_l);
        idx_bit = W'(1) << idx_q;
        // A > B means the trial bit overshoots and must be cleared
        kept    = bus.cmp_g ? (trial_q & ~idx_bit) : trial_q;

        case (state_q)
            IDLE: begin
                trial_d = '0;
                if (bus.start) begin
                    idx_d    = IDX_TOP;
                    trial_d  = W'(1) << IDX_TOP;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = TRY;
                end
            end
            TRY: begin
                if (!one_hot) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                    trial_d  = '0;
                    state_d  = IDLE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (bus.cmp_e) begin
                    result_d = trial_q;
                    done_d   = 1'b1;
                    trial_d  = '0;
                    state_d  = IDLE;
                end
`endif
                else if (idx_q == '0) begin
                    result_d = kept;
                    done_d   = 1'b1;
                    trial_d  = '0;
                    state_d  = IDLE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    trial_d = kept | (idx_bit >> 1);
                end
            end
            default: begin
                state_d = IDLE;
                trial_d = '0;
            end
        endcase
    end

    assign bus.cmp_a  = trial_q;
    assign bus.busy   = (state_q == TRY);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - scoreboard bench for sar_search_ctrl with comparator model
module tb_sar_search_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] b_val;
    logic force_bad;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_b = 0;
    int   cur_s = 0;

    typedef struct {
        int res;
        int err;
        int at;
    } exp_t;
    exp_t sb[$];

    sar_search_ctrl_if #(.W(W)) bus ();

    sar_search_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational comparator on B, with a fault override forcing all flags low
    assign bus.cmp_e = force_bad ? 1'b0 : (bus.cmp_a == b_val);
    assign bus.cmp_g = force_bad ? 1'b0 : (bus.cmp_a >  b_val);
    assign bus.cmp_l = force_bad ? 1'b0 : (bus.cmp_a <  b_val);

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Search length from the value itself: an exact hit happens at the step
    // that probes B's lowest set bit
    function automatic int exp_latency(int b);
`ifdef SAR_EARLY_EXIT_EN
        for (int k = 0; k < W; k++)
            if (((b >> k) & 1) == 1) return W - k;
        return W;
`else
        return W;
`endif
    endfunction

    // Trial at step j: B's bits above the probed position, plus the probe bit
    function automatic int exp_trial(int b, int j);
        int hi;
        hi = (b >> (W - j + 1)) << (W - j + 1);
        return hi | (1 << (W - j));
    endfunction

    // Called at a negedge: drives start for one cycle and records the expectation
    task automatic issue(int b, bit bad, bit expect_done);
        exp_t e;
        b_val     = W'(b);
        force_bad = bad;
        bus.start = 1'b1;
        cur_b     = b;
        cur_s     = cyc + 1;
        if (expect_done) begin
            e.res = bad ? 0 : b;
            e.err = bad ? 1 : 0;
            e.at  = cyc + 1 + (bad ? 1 : exp_latency(b));
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        force_bad = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every done and tracks the trial sequence
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", int'(bus.result), e.res);
                    check("err", int'(bus.err), e.err);
                    check("done_cycle", cyc, e.at);
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end
            if (bus.busy) begin
                int j;
                j = cyc - cur_s + 1;
                if (j < 1 || j > W) check("busy_overrun", j, W);
                else check("trial", int'(bus.cmp_a), exp_trial(cur_b, j));
            end else begin
                check("idle_cmp_a", int'(bus.cmp_a), 0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        b_val     = '0;
        force_bad = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmp_a", int'(bus.cmp_a), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_err", int'(bus.err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values from the search rules
        issue(5, 0, 1);  wait_done();
        @(negedge clk);
        issue(4, 0, 1);  wait_done();
        @(negedge clk);
        issue(0, 0, 1);  wait_done();
        @(negedge clk);
        issue(15, 0, 1); wait_done();
        @(negedge clk);

        // Flags not one-hot at the first sample
        issue(9, 1, 1);  wait_done();
        @(negedge clk);
        check("err_idle_busy", int'(bus.busy), 0);

        // Reset asserted for edge 2 of a search: no done, all outputs cleared
        issue(14, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cmp_a", int'(bus.cmp_a), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_err", int'(bus.err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(13, 0, 1); wait_done();
        @(negedge clk);

        // Start pulsed while busy must not restart the search
        issue(6, 0, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        @(negedge clk);

        // Back-to-back: start raised on the done cycle
        issue(11, 0, 1);
        wait_done();
        issue(3, 0, 1);
        check("b2b_busy", int'(bus.busy), 1);
        wait_done();
        @(negedge clk);

        // Randomized searches, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            issue(int'($urandom_range(0, (1 << W) - 1)), 0, 1);
            wait_done();
            if ($urandom_range(0, 2) != 0) @(negedge clk);
        end
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
